// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code consumer: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into single key events, and tracks the held key, typematic repeats and press count.
module ps2_key_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic       key_down,
    output logic [7:0] cur_code,
    output logic       cur_ext,
    output logic [7:0] press_count
);

    // Handshake: kbd_ready high means kbd_data holds the FIFO head. A byte is
    // taken only in IDLE with kbd_ready high; the pop is a single registered low
    // cycle on kbd_nextdata_n (ACK), followed by SETTLE so the receiver's ready
    // has updated before IDLE samples it again.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      byte_r;
    logic            ext_p, brk_p;
    logic [TO_W-1:0] to_cnt;

    logic is_e0, is_f0, emit, held_match, code_match, to_run;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (kbd_ready) state_nx = ACK;
            ACK:     state_nx = SETTLE;
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        is_e0      = (byte_r == 8'hE0);
        is_f0      = (byte_r == 8'hF0);
        emit       = (state == SETTLE) && !is_e0 && !is_f0;
        code_match = (byte_r == cur_code) && (ext_p == cur_ext);
        held_match = key_down && code_match;
        to_run     = (state == IDLE) && !kbd_ready && (ext_p || brk_p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kbd_nextdata_n <= 1'b1;
            byte_r         <= 8'h00;
            ext_p          <= 1'b0;
            brk_p          <= 1'b0;
            to_cnt         <= '0;
            key_valid      <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_break      <= 1'b0;
            key_repeat     <= 1'b0;
            key_down       <= 1'b0;
            cur_code       <= 8'h00;
            cur_ext        <= 1'b0;
            press_count    <= 8'h00;
        end else begin
            kbd_nextdata_n <= 1'b1;
            key_valid      <= 1'b0;

            if (state == IDLE && kbd_ready) begin
                byte_r         <= kbd_data;
                kbd_nextdata_n <= 1'b0;
            end

            if (state == SETTLE && is_e0) begin
                ext_p  <= 1'b1;
                to_cnt <= TO_W'(TIMEOUT_CYCLES);
            end else if (state == SETTLE && is_f0) begin
                brk_p  <= 1'b1;
                to_cnt <= TO_W'(TIMEOUT_CYCLES);
            end else if (to_run) begin
                // A prefix whose key never arrives is dropped without an event.
                if (to_cnt == '0) begin
                    ext_p <= 1'b0;
                    brk_p <= 1'b0;
                end else begin
                    to_cnt <= to_cnt - 1'b1;
                end
            end

            if (emit) begin
                key_valid <= 1'b1;
                key_code  <= byte_r;
                key_ext   <= ext_p;
                key_break <= brk_p;
                ext_p     <= 1'b0;
                brk_p     <= 1'b0;
                to_cnt    <= '0;
                if (!brk_p) begin
                    if (held_match) begin
                        key_repeat <= 1'b1;
                    end else begin
                        key_repeat  <= 1'b0;
                        cur_code    <= byte_r;
                        cur_ext     <= ext_p;
                        key_down    <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end
                end else begin
                    // cur_code/cur_ext keep the released key for the display.
                    key_repeat <= 1'b0;
                    if (code_match) key_down <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: behavioural receiver FIFO, a vector table
// of single-byte steps, and hand-written multi-cycle sequences.
module tb_ps2_key_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic       key_down;
    logic [7:0] cur_code;
    logic       cur_ext;
    logic [7:0] press_count;

    ps2_key_sequencer #(.TIMEOUT_CYCLES(50), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
        .key_down(key_down), .cur_code(cur_code), .cur_ext(cur_ext),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext, brk, rep, down;
        logic [7:0] cur;
        logic       cure;
        logic [7:0] pc;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        ev_t        e;
    } vec_t;

    logic [7:0] fifo[$];
    ev_t        ev_q[$];
    int         ev_cyc[$];
    vec_t       vt[$];
    int cyc = 0, pops = 0, dbl_low = 0, underflow = 0;
    int n_checks = 0, n_err = 0;
    logic prev_low = 1'b0;

    // Receiver model: pops on the edge opposite the DUT's, records events.
    always @(negedge clk) begin
        cyc++;
        if (kbd_nextdata_n === 1'b0) begin
            pops++;
            if (prev_low) dbl_low++;
            if (fifo.size() == 0) underflow++;
            else void'(fifo.pop_front());
        end
        prev_low = (kbd_nextdata_n === 1'b0);
        if (key_valid === 1'b1) begin
            ev_q.push_back('{key_code, key_ext, key_break, key_repeat, key_down,
                             cur_code, cur_ext, press_count});
            ev_cyc.push_back(cyc);
        end
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        kbd_ready = 1'b1;
        kbd_data  = fifo[0];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input ev_t g, input ev_t x);
        chk({tag, "_code"}, 32'(g.code), 32'(x.code));
        chk({tag, "_ext"},  32'(g.ext),  32'(x.ext));
        chk({tag, "_brk"},  32'(g.brk),  32'(x.brk));
        chk({tag, "_rep"},  32'(g.rep),  32'(x.rep));
        chk({tag, "_down"}, 32'(g.down), 32'(x.down));
        chk({tag, "_cur"},  32'(g.cur),  32'(x.cur));
        chk({tag, "_cure"}, 32'(g.cure), 32'(x.cure));
        chk({tag, "_pc"},   32'(g.pc),   32'(x.pc));
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ev_q.delete();
        ev_cyc.delete();
        pops = 0;
    endtask

    // Push one byte and wait a bounded time for an event.
    task automatic apply_byte(input logic [7:0] b, output logic got, output ev_t e);
        int n0;
        n0  = ev_q.size();
        got = 1'b0;
        e   = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        step();
        push(b);
        for (int k = 0; k < 8; k++) begin
            step();
            if (ev_q.size() > n0) begin
                got = 1'b1;
                e   = ev_q[n0];
                break;
            end
        end
    endtask

    task automatic add_pfx(input logic [7:0] b);
        vt.push_back('{b, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00}});
    endtask

    task automatic add_ev(input logic [7:0] b, input logic ext, brk, rep, down,
                          input logic [7:0] cur, input logic cure, input logic [7:0] pc);
        vt.push_back('{b, 1'b1, '{b, ext, brk, rep, down, cur, cure, pc}});
    endtask

    initial begin
        logic got;
        ev_t  e;
        int   reps;
        rst       = 1'b1;
        kbd_ready = 1'b0;
        kbd_data  = 8'h00;

        // make/break, extended, typematic, mismatched ext, foreign break, AA
        add_ev (8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1);
        add_pfx(8'hF0);
        add_ev (8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd1);
        add_pfx(8'hE0);
        add_ev (8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2);
        add_pfx(8'hF0);
        add_pfx(8'hE0);
        add_ev (8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2);
        add_ev (8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3);
        add_ev (8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 8'd3);
        add_ev (8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 8'd3);
        add_pfx(8'hF0);
        add_ev (8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd3);
        add_ev (8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 8'd4);
        add_pfx(8'hE0);
        add_ev (8'h32, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32, 1'b1, 8'd5);
        add_pfx(8'hF0);
        add_ev (8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 8'd5);
        add_ev (8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b0, 8'd6);
        add_ev (8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'd7);

        reset_dut();
        chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
        chk("rst_outputs", {key_valid, key_ext, key_break, key_repeat, key_down, cur_ext,
                            key_code, cur_code, press_count}, 32'd0);

        foreach (vt[i]) begin
            apply_byte(vt[i].b, got, e);
            chk($sformatf("v%0d_event", i), 32'(got), 32'(vt[i].ev));
            if (vt[i].ev && got) chk_ev($sformatf("v%0d", i), e, vt[i].e);
        end
        chk("table_pops", pops, vt.size());

        // back-to-back 1C F0 1C: latency 3, one byte per 3 cycles, 3 pops
        reset_dut();
        step();
        push(8'h1C);
        push(8'hF0);
        push(8'h1C);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("b2b_valid_k%0d", k), 32'(key_valid), 32'((k == 3) || (k == 9)));
        end
        chk("b2b_events", ev_q.size(), 2);
        chk("b2b_pops", pops, 3);
        if (ev_q.size() == 2) begin
            chk("b2b_spacing", ev_cyc[1] - ev_cyc[0], 6);
            chk_ev("b2b_e0", ev_q[0], '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1});
            chk_ev("b2b_e1", ev_q[1], '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd1});
        end

        // 256 alternating new makes wrap press_count
        reset_dut();
        step();
        for (int k = 0; k < 256; k++) push((k % 2 == 0) ? 8'h1C : 8'h32);
        for (int k = 0; k < 1000 && ev_q.size() < 256; k++) step();
        step();
        chk("wrap_events", ev_q.size(), 256);
        chk("wrap_pc", 32'(press_count), 32'd0);
        reps = 0;
        foreach (ev_q[i]) if (ev_q[i].rep) reps++;
        chk("wrap_repeats", reps, 0);
        if (ev_q.size() == 256) chk("wrap_pc_255", 32'(ev_q[254].pc), 32'd255);

        // prefix timeout: expired after long idle, still pending after short idle
        reset_dut();
        apply_byte(8'hF0, got, e);
        chk("to_long_pfx_noevent", 32'(got), 32'd0);
        repeat (60) step();
        apply_byte(8'h1C, got, e);
        chk("to_long_event", 32'(got), 32'd1);
        chk("to_long_code", 32'(e.code), 32'h1C);
        chk("to_long_brk", 32'(e.brk), 32'd0);
        apply_byte(8'hF0, got, e);
        repeat (40) step();
        apply_byte(8'h1C, got, e);
        chk("to_short_event", 32'(got), 32'd1);
        chk("to_short_brk", 32'(e.brk), 32'd1);

        // reset asserted in the ACK cycle of E0
        step();
        push(8'hE0);
        step();
        chk("ack_low", 32'(kbd_nextdata_n), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ackrst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
        chk("ackrst_outputs", {key_valid, key_ext, key_break, key_repeat, key_down, cur_ext,
                               key_code, cur_code, press_count}, 32'd0);
        apply_byte(8'h1C, got, e);
        chk("ackrst_event", 32'(got), 32'd1);
        chk("ackrst_ext", 32'(e.ext), 32'd0);
        chk("ackrst_pc", 32'(e.pc), 32'd1);

        chk("double_low_pops", dbl_low, 0);
        chk("pop_while_empty", underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Consumer-side controller for the PS/2 keyboard receiver. It pops scan-code bytes from the receiver FIFO through the `ready`/`nextdata_n` handshake. It folds the `E0` (extended) and `F0` (break) prefixes into single key events and tracks the currently held key, typematic repeats and a press counter. It sits between the PS/2 receiver and the display/ASCII logic, and is the only block allowed to drive the receiver's `nextdata_n`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1000000: idle cycles after a prefix byte before the pending prefix is discarded (20 ms at 50 MHz).
- `TO_W`, default 20: width of the timeout counter. Must satisfy `2^TO_W > TIMEOUT_CYCLES`.

Ports:
- `clk` input 1: system clock, same clock as the receiver.
- `rst` input 1: synchronous, active-high reset.
- `kbd_data` input 8: receiver FIFO head byte.
- `kbd_ready` input 1: receiver FIFO non-empty.
- `kbd_nextdata_n` output 1: registered, active-low pop strobe to the receiver.
- `key_valid` output 1: one-cycle pulse; the `key_*` outputs are valid in this cycle.
- `key_code` output 8: final (non-prefix) scan code of the event.
- `key_ext` output 1: event was preceded by `E0`.
- `key_break` output 1: event was preceded by `F0` (release).
- `key_repeat` output 1: make event whose code and ext match the held key.
- `key_down` output 1: level; a key is currently held.
- `cur_code` output 8: code of the held key (last make).
- `cur_ext` output 1: ext flag of the held key.
- `press_count` output 8: count of new (non-repeat) make events; wraps.

## Operation

- FSM states: IDLE, ACK, SETTLE.
  - IDLE: `kbd_nextdata_n`=1. If `kbd_ready`=1, latch `kbd_data` into `byte_r`, drive `kbd_nextdata_n`<=0, go to ACK.
  - ACK: `kbd_nextdata_n` is low for exactly this cycle. Drive `kbd_nextdata_n`<=1, go to SETTLE.
  - SETTLE: decode `byte_r` (see below), go to IDLE. This state gives the receiver's `ready`/read pointer one cycle to update, so IDLE never samples a stale `ready`.
- Decode in SETTLE:
  - `E0`: set `ext_p`, load the timeout counter, no event.
  - `F0`: set `brk_p`, load the timeout counter, no event.
  - Prefix order is free (`E0 F0 xx` and `F0 E0 xx` are equivalent). Duplicate prefixes are harmless.
  - Any other byte (including `AA`, `FA`, `E1`) emits an event on the next cycle:
    - `key_valid`=1 for one cycle.
    - `key_code`=byte, `key_ext`=`ext_p`, `key_break`=`brk_p`.
    - `ext_p` and `brk_p` clear.
    - `key_code`/`key_ext`/`key_break`/`key_repeat` hold their values until the next event.
- Held-key tracking, applied in the same cycle as the event:
  - Make with `key_down`=1 and (code, ext) == (`cur_code`, `cur_ext`): `key_repeat`=1, `press_count` unchanged.
  - Any other make: `key_repeat`=0, `cur_code`/`cur_ext` load, `key_down`=1, `press_count`+1 (255 -> 0).
  - Break matching (`cur_code`, `cur_ext`): `key_down`=0; `cur_code`/`cur_ext` retain their last value.
  - Break of a non-matching key: no state change besides the event outputs; `key_repeat`=0.
- Prefix timeout:
  - While `ext_p` or `brk_p` is set and the FSM is in IDLE with `kbd_ready`=0, the counter decrements.
  - At 0, `ext_p` and `brk_p` clear silently (no event).
  - Any popped byte reloads or stops the counter.

## Timing

- Reset values:
  - `kbd_nextdata_n`=1.
  - `key_valid`, `key_ext`, `key_break`, `key_repeat`, `key_down`, `cur_ext`=0.
  - `key_code`, `cur_code`, `press_count`=0.
  - FSM in IDLE, prefixes clear, timeout counter idle.
- Throughput: one byte per 3 cycles when the FIFO is continuously non-empty.
- Latency: `key_valid` is high 3 cycles after the IDLE cycle that captured the final byte (capture, ACK, SETTLE, then the pulse cycle, which overlaps the next IDLE).
- `kbd_nextdata_n` is never low in two consecutive cycles and is never low while `kbd_ready`=0 was seen in the capturing IDLE cycle.
- `rst` mid-operation, including during ACK: the next edge forces all reset values. A partially processed byte is lost; its pop may already have occurred.
- The block does not reset the receiver; receiver overflow is handled elsewhere.

## Test plan

- Make then break: FIFO bytes `1C`, `F0`, `1C` -> event 1: code=1C ext=0 brk=0 rep=0, `key_down`=1, `press_count`=1. Event 2: code=1C brk=1, `key_down`=0, `cur_code`=1C. Exactly 3 `kbd_nextdata_n` low pulses.
- Extended key: `E0 75`, then `F0 E0 75` -> make code=75 ext=1, then break code=75 ext=1 brk=1, `key_down`=0. Exactly 2 events.
- Typematic: `1C 1C 1C F0 1C` -> events 2 and 3 have `key_repeat`=1, `press_count`=1 throughout, final `key_down`=0. Then `32` -> `press_count`=2, `cur_code`=32.
- Counter wrap: 256 alternating makes `1C`/`32` -> `press_count` returns to 0, `key_repeat` never set.
- Prefix timeout (`TIMEOUT_CYCLES`=50): `F0`, idle 60 cycles, then `1C` -> event code=1C brk=0. With only 40 idle cycles -> brk=1.
- Reset during ACK: assert `rst` in the ACK cycle of `E0` -> next cycle `kbd_nextdata_n`=1 and all outputs at reset values. A following `1C` yields ext=0, `press_count`=1.
